// File: rtl/uart_rx_sampler_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive sampler:
//   - receiver state enumeration
//   - oversampling constants (16 ticks per bit, centre sample at tick 8)
//   - data width of one character
//   - 3-input majority helper used for the bit decision
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 8;
    localparam int DATA_BITS  = 8;

    // Sample points around the bit centre and the last tick of a bit period.
    localparam logic [3:0] SAMPLE_FIRST = 4'(SAMPLE_MID - 1);
    localparam logic [3:0] SAMPLE_CTR   = 4'(SAMPLE_MID);
    localparam logic [3:0] SAMPLE_LAST  = 4'(SAMPLE_MID + 1);
    localparam logic [3:0] SAMPLE_END   = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] BIT_LAST     = 3'(DATA_BITS - 1);

    // Majority of three samples: filters a single noisy sample near mid-bit.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running divider producing the oversample tick.
// The counter runs 0..CLK_DIV-1; tick is high for exactly the cycle in which
// the counter holds CLK_DIV-1. tick is registered: it is computed from the
// counter's next value so it stays aligned with the counter itself.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset (counter to 0, tick low)
//   tick   out  one-cycle oversample strobe, period CLK_DIV clocks
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          r_tick;

    // Next divider value: wrap to zero after the terminal count.
    always_comb begin
        w_count_next = r_count;
        if (r_count == CNT_LAST) begin
            w_count_next = '0;
        end else begin
            w_count_next = r_count + CW'(1);
        end
    end

    // Divider counter and registered tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_tick  <= (w_count_next == CNT_LAST);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// 8N1 UART receiver with 16x oversampling and majority-of-three bit decision.
// The line is synchronised through two flops, sampled on oversample ticks, and
// each bit is decided from the samples at tick 7, 8 and 9 of the bit period.
// The completed byte is presented with a valid/ready handshake; a byte that
// completes while the previous one is still unaccepted is dropped and
// reported with a one-cycle overrun pulse.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   rx_in      in   asynchronous serial line, idles high
//   rx_data    out  received byte (LSB first on the line)
//   rx_valid   out  rx_data/frame_err valid, held until accepted
//   rx_ready   in   consumer accepts when rx_valid && rx_ready
//   frame_err  out  stop bit of the byte in rx_data was sampled 0
//   overrun    out  one-cycle pulse: a completed byte was discarded
//   busy       out  receiver is inside a frame (state != IDLE)
// -----------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    // Line synchroniser
    logic        r_sync1;
    logic        r_rx_s;

    // Receiver state and counters
    uart_state_e r_state;
    uart_state_e w_state_next;
    logic [3:0]  r_sample_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_s7;
    logic        r_s8;

    // Output registers
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_frame_err;
    logic        r_overrun;
    logic        r_busy;

    // Decoded strobes
    logic        w_tick;
    logic        w_dec_tick;
    logic        w_bit_end;
    logic        w_decision;
    logic        w_frame_done;

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_rx_s  <= r_sync1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and frame strobes.
    always_comb begin
        w_state_next = r_state;
        w_frame_done = 1'b0;
        w_dec_tick   = w_tick && (r_sample_cnt == SAMPLE_LAST);
        w_bit_end    = w_tick && (r_sample_cnt == SAMPLE_END);
        // Third sample is the live one on the decision tick.
        w_decision   = maj3(r_s7, r_s8, r_rx_s);
        case (r_state)
            ST_IDLE: begin
                if (w_tick && !r_rx_s) begin
                    w_state_next = ST_START;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_START: begin
                // A start bit that reads high at mid-bit was a glitch.
                if (w_dec_tick && w_decision) begin
                    w_state_next = ST_IDLE;
                end else if (w_bit_end) begin
                    w_state_next = ST_DATA;
                end else begin
                    w_state_next = ST_START;
                end
            end
            ST_DATA: begin
                if (w_bit_end && (r_bit_idx == BIT_LAST)) begin
                    w_state_next = ST_STOP;
                end else begin
                    w_state_next = ST_DATA;
                end
            end
            ST_STOP: begin
                // Leave at mid stop bit so the next start edge is never missed.
                if (w_dec_tick) begin
                    w_state_next = ST_IDLE;
                    w_frame_done = 1'b1;
                end else begin
                    w_state_next = ST_STOP;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Oversample counter and mid-bit sample capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample_cnt <= 4'd0;
            r_s7         <= 1'b1;
            r_s8         <= 1'b1;
        end else begin
            // Held at zero in IDLE so the start detect tick is sample 0.
            if ((r_state == ST_IDLE) || (w_state_next == ST_IDLE)) begin
                r_sample_cnt <= 4'd0;
            end else if (w_tick) begin
                r_sample_cnt <= r_sample_cnt + 4'd1;
            end else begin
                r_sample_cnt <= r_sample_cnt;
            end
            if (w_tick && (r_sample_cnt == SAMPLE_FIRST)) begin
                r_s7 <= r_rx_s;
            end else begin
                r_s7 <= r_s7;
            end
            if (w_tick && (r_sample_cnt == SAMPLE_CTR)) begin
                r_s8 <= r_rx_s;
            end else begin
                r_s8 <= r_s8;
            end
        end
    end

    // Bit index and data shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            if (r_state == ST_START) begin
                r_bit_idx <= 3'd0;
            end else if ((r_state == ST_DATA) && w_bit_end) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end else begin
                r_bit_idx <= r_bit_idx;
            end
            if ((r_state == ST_DATA) && w_dec_tick) begin
                r_shift[r_bit_idx] <= w_decision;
            end else begin
                r_shift <= r_shift;
            end
        end
    end

    // Output handshake, overrun pulse and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_data   <= 8'd0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            r_busy    <= (w_state_next != ST_IDLE);
            if (w_frame_done) begin
                // Slot is free if empty or being drained on this very edge.
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data   <= r_shift;
                    r_frame_err <= ~w_decision;
                    r_rx_valid  <= 1'b1;
                end else begin
                    r_overrun   <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end else begin
                r_rx_valid <= r_rx_valid;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = r_busy;

endmodule
